// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and types for the multi-cycle RISC-V control unit.
// Opcodes, FSM states, ALU/operand encodings and the strobe bundle.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_EXEC_R     = 4'd2,
    S_EXEC_I     = 4'd3,
    S_EXEC_AUIPC = 4'd4,
    S_MEM_ADDR   = 4'd5,
    S_MEM_RD     = 4'd6,
    S_MEM_WR     = 4'd7,
    S_LOAD_WB    = 4'd8,
    S_ALU_WB     = 4'd9,
    S_BRANCH     = 4'd10,
    S_TRAP       = 4'd11
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC2_REG  = 2'b00;
  localparam logic [1:0] SRC2_FOUR = 2'b01;
  localparam logic [1:0] SRC2_IMM  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       alu_src_1;
    logic [1:0] alu_src_2;
    logic       reg_write;
    logic       instr_retired;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Shared instruction/data memory request port.
// The control unit is the master; memory answers with mem_ready.
interface multicycle_control_unit_if;

  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output i_or_d,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  i_or_d,
    output mem_ready
  );

endinterface

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Counts consecutive stalled memory cycles.
// expired flags the cycle in which the stall reaches the limit.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic clear,
  output logic expired
);

  localparam int LIMIT =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds stalls already seen; the current one makes cnt_q+1
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !waiting) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT_CYCLES > 0) && waiting
                && (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM with memory stall handling,
// illegal-opcode and bus-timeout traps and a retired-instruction counter.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STATE_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             opcode,
  multicycle_control_unit_if.master mem,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   pc_source,
  output logic                   ir_write,
  output logic                   mem_to_reg,
  output logic [1:0]             alu_op,
  output logic                   alu_src_1,
  output logic [1:0]             alu_src_2,
  output logic                   reg_write,
  output logic                   instr_retired,
  output logic [DATA_WIDTH-1:0]  instret,
  output logic                   illegal_instr,
  output logic                   bus_error,
  output logic [STATE_WIDTH-1:0] state
);

  state_e                state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [DATA_WIDTH-1:0] instret_q, instret_d;
  logic                  illegal_q, illegal_d;
  logic                  bus_err_q, bus_err_d;
  ctrl_t                 ctrl;
  logic                  waiting;
  logic                  expired;

  assign waiting = !mem.mem_ready
    && (state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR});

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .waiting(waiting),
    .clear  (state_d != state_q),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      is_store_q <= 1'b0;
      instret_q  <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      instret_q  <= instret_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem.mem_ready) begin
          state_d = S_DECODE;
        end else if (expired) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        is_store_d = (opcode == STORE);
        unique case (1'b1)
          (opcode == OP):     state_d = S_EXEC_R;
          (opcode == OP_IMM): state_d = S_EXEC_I;
          (opcode == AUIPC):  state_d = S_EXEC_AUIPC;
          (opcode == LOAD),
          (opcode == STORE):  state_d = S_MEM_ADDR;
          (opcode == BRANCH): state_d = S_BRANCH;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R,
      S_EXEC_I,
      S_EXEC_AUIPC: state_d = S_ALU_WB;
      S_MEM_ADDR: begin
        state_d = is_store_q ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        if (mem.mem_ready) begin
          state_d = S_LOAD_WB;
        end else if (expired) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_MEM_WR: begin
        if (mem.mem_ready) begin
          state_d = S_FETCH;
        end else if (expired) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_LOAD_WB,
      S_ALU_WB,
      S_BRANCH: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_1 = 1'b1;
        ctrl.alu_src_2 = SRC2_FOUR;
        ctrl.ir_write  = mem.mem_ready;
        ctrl.pc_write  = mem.mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_1 = 1'b1;
        ctrl.alu_src_2 = SRC2_IMM;
      end
      S_EXEC_R: begin
        ctrl.alu_src_2 = SRC2_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        ctrl.alu_src_2 = SRC2_IMM;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EXEC_AUIPC: begin
        ctrl.alu_src_1 = 1'b1;
        ctrl.alu_src_2 = SRC2_IMM;
      end
      S_MEM_ADDR: ctrl.alu_src_2 = SRC2_IMM;
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write     = 1'b1;
        ctrl.i_or_d        = 1'b1;
        ctrl.instr_retired = mem.mem_ready;
      end
      S_LOAD_WB: begin
        ctrl.reg_write     = 1'b1;
        ctrl.mem_to_reg    = 1'b1;
        ctrl.instr_retired = 1'b1;
      end
      S_ALU_WB: begin
        ctrl.reg_write     = 1'b1;
        ctrl.instr_retired = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_op        = ALU_SUB;
        ctrl.alu_src_2     = SRC2_REG;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
        ctrl.instr_retired = 1'b1;
      end
      default: ctrl = '0;
    endcase
    // strobes must not reach the datapath while reset is held
    if (reset) begin
      ctrl = '0;
    end
  end

  assign instret_d =
    instret_q + DATA_WIDTH'(ctrl.instr_retired);

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign ir_write      = ctrl.ir_write;
  assign mem.i_or_d    = ctrl.i_or_d;
  assign mem.mem_read  = ctrl.mem_read;
  assign mem.mem_write = ctrl.mem_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_op        = ctrl.alu_op;
  assign alu_src_1     = ctrl.alu_src_1;
  assign alu_src_2     = ctrl.alu_src_2;
  assign reg_write     = ctrl.reg_write;
  assign instr_retired = ctrl.instr_retired;
  assign instret       = instret_q;
  assign illegal_instr = illegal_q;
  assign bus_error     = bus_err_q;
  assign state         = STATE_WIDTH'(state_q);

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multi-cycle successor to the single-cycle opcode decoder. It sequences each RISC-V instruction through fetch, decode, execute, memory and writeback states, and emits per-state datapath strobes. It handshakes with a shared instruction/data memory port that can stall, and traps on illegal opcodes or memory timeout. It sits between the instruction register (opcode input) and the multi-cycle datapath: PC, old-PC, IR, A/B, ALUOut and MDR registers.

Parameters:
DATA_WIDTH, 32, width of the retired-instruction counter instret
TIMEOUT_CYCLES, 16, consecutive stalled memory cycles before bus-error trap; 0 disables the timeout
STATE_WIDTH, 4, width of the state register and of the state debug output

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high
opcode  in  7  instr[6:0] from the IR; sampled in DECODE only
mem_ready  in  1  memory completes the current request this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if the datapath branch-taken condition holds
pc_source  out  1  0 = ALU result, 1 = ALUOut register
ir_write  out  1  load the IR and the old-PC register
i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  read request, held until mem_ready
mem_write  out  1  write request, held until mem_ready
mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = MDR
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
alu_src_1  out  1  0 = A (rs1), 1 = old PC
alu_src_2  out  2  00 = B (rs2), 01 = constant 4, 10 = immediate
reg_write  out  1  register-file write
instr_retired  out  1  one-cycle pulse when an instruction completes
instret  out  DATA_WIDTH  count of retired instructions
illegal_instr  out  1  sticky flag: illegal opcode
bus_error  out  1  sticky flag: memory timeout
state  out  STATE_WIDTH  current state, for debug

Behaviour:
- Reset is synchronous and active-high on clk. While reset is high, every strobe output is forced to 0. On reset the state becomes FETCH and instret, illegal_instr and bus_error become 0.
- Outputs are Moore-decoded from state, except pc_write and ir_write in FETCH, which are also gated by mem_ready.
- Unlisted strobes are 0 in every state. alu_src_1, alu_src_2 and alu_op are 0 unless stated.
- FETCH: mem_read=1, i_or_d=0, alu_src_1=1, alu_src_2=01, pc_source=0, ir_write=mem_ready, pc_write=mem_ready. On mem_ready go to DECODE, otherwise stay.
- DECODE: alu_src_1=1, alu_src_2=10 (precomputes the branch target into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0010111 -> EXEC_AUIPC
  - 0000011 / 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - any other opcode -> TRAP, and set illegal_instr.
- EXEC_R: alu_src_2=00, alu_op=10. EXEC_I: alu_src_2=10, alu_op=10. EXEC_AUIPC: alu_src_1=1, alu_src_2=10. All three go to ALU_WB.
- MEM_ADDR: alu_src_2=10. Goes to MEM_RD for a load or MEM_WR for a store; the opcode is latched at DECODE.
- MEM_RD: mem_read=1, i_or_d=1. On mem_ready go to LOAD_WB.
- MEM_WR: mem_write=1, i_or_d=1. On mem_ready go to FETCH and retire.
- LOAD_WB: reg_write=1, mem_to_reg=1, then FETCH and retire. ALU_WB: reg_write=1, then FETCH and retire.
- BRANCH: alu_op=01, alu_src_2=00, pc_write_cond=1, pc_source=1, then FETCH and retire.
- Retire: instr_retired=1 in the retiring cycle; instret increments on that edge and wraps modulo 2^DATA_WIDTH.
- Timeout counter:
  - Counts consecutive cycles in FETCH, MEM_RD or MEM_WR with mem_ready=0; clears on any state change or on mem_ready=1.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES, the next state is TRAP and bus_error is set.
  - mem_ready=1 on the same cycle wins over the timeout.
- TRAP: all strobes 0. Held until reset; the flags stay sticky until reset.
- Reset mid-instruction, including a stalled MEM_WR: strobes drop in the reset cycle, no retire, restart in FETCH.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants (OP, OP_IMM, AUIPC, LOAD, STORE, BRANCH)
  - the state enum
  - alu_op encodings (ALU_ADD, ALU_SUB, ALU_FUNCT)
  - alu_src_2 encodings (SRC2_REG, SRC2_FOUR, SRC2_IMM).
- One sub-module, mem_wait_timer: the parametrised stall counter, with inputs clk, reset, waiting and clear, and output expired.

Test Plan:
- Reset, mem_ready=1, opcode 0010011 -> states FETCH, DECODE, EXEC_I, ALU_WB. reg_write=1 in cycle 4, instr_retired pulses, instret=1.
- Opcode 0000011, mem_ready=1 -> FETCH, DECODE, MEM_ADDR, MEM_RD, LOAD_WB. mem_to_reg=1 and reg_write=1 only in LOAD_WB, instret+1.
- Opcode 0100011 with mem_ready low for 3 cycles in MEM_WR -> mem_write=1 for 4 cycles, i_or_d=1, reg_write never 1. Retire on the handshake cycle, then FETCH.
- Opcode 1100011 -> BRANCH with alu_op=01, pc_write_cond=1, pc_source=1 for one cycle, then FETCH, instret+1.
- Opcode 1111111 -> DECODE then TRAP. illegal_instr=1, all strobes 0 for 20 cycles, instret unchanged. Reset clears the flag and resumes at FETCH.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH -> TRAP after 4 waiting cycles, bus_error=1. Repeat with mem_ready=1 on cycle 4 -> DECODE, no bus_error.
- Assert reset during a stalled MEM_WR -> mem_write=0 in that cycle, state FETCH next, instret=0.
